ro_event_packer: RTL and testbench

//  Downstream consumer of the shared unison readout bus read_out_I[1:0] / read_out_Q[1:0].

---
 rtl/ro_event_packer_if.sv | 16 +
 rtl/ro_event_packer.sv | 146 ++++++++++++++
 tb/tb_ro_event_packer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_event_packer_if.sv
// ro_event_packer_if
//   Packet stream between the event packer and its consumer.
//   pkt_data  : packet at the FIFO head, {ts, chan, I_eve, I_pol, Q_eve, Q_pol}
//   pkt_valid : FIFO holds at least one packet
//   pkt_ready : consumer accepts the head packet this cycle
//   master modport drives data/valid, slave modport drives ready.
interface ro_event_packer_if #(
    parameter int unsigned PKT_W = 20
);
    logic [PKT_W-1:0] pkt_data;
    logic             pkt_valid;
    logic             pkt_ready;

    modport master (output pkt_data, output pkt_valid, input pkt_ready);
    modport slave  (input pkt_data, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/ro_event_packer.sv
// ro_event_packer
//   Samples the time-multiplexed unison readout bus every cycle, tags each
//   active slot with its channel id and frame timestamp, and queues packets
//   in a show-ahead FIFO drained over a valid/ready stream.
// Ports
//   clk_master   : master clock, all logic on posedge
//   rstb         : asynchronous active-low reset
//   cap_en       : 1 = packets are captured; 0 = counters run, no pushes
//   read_out_I/Q : [0] event, [1] polarity x event
//   pkt          : packet stream (master side), see ro_event_packer_if
//   fifo_level   : registered FIFO occupancy, 0..2**FIFO_AW
//   overflow     : sticky, set when a packet is dropped on a full FIFO
//   ovf_clr      : synchronous clear of overflow and drop_cnt
//   drop_cnt     : dropped packet count, saturating at 255
module ro_event_packer #(
    parameter int unsigned CH_BITS     = 4,
    parameter int unsigned TS_BITS     = 12,
    parameter int unsigned SLOT_OFFSET = 1,
    parameter int unsigned FIFO_AW     = 3
) (
    input  logic               clk_master,
    input  logic               rstb,
    input  logic               cap_en,
    input  logic [1:0]         read_out_I,
    input  logic [1:0]         read_out_Q,
    ro_event_packer_if.master  pkt,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    input  logic               ovf_clr,
    output logic [7:0]         drop_cnt
);
    localparam int unsigned PKT_W = TS_BITS + CH_BITS + 4;
    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    // Free-running slot / frame counters
    logic [CH_BITS-1:0] slot;
    logic [TS_BITS-1:0] ts;

    // Stage 1 sample registers
    logic [1:0]         s1_i;
    logic [1:0]         s1_q;
    logic [CH_BITS-1:0] s1_slot;
    logic [TS_BITS-1:0] s1_ts;
    logic               s1_cap;

    // FIFO storage and pointers
    logic [PKT_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    logic [CH_BITS-1:0] chan;
    logic [PKT_W-1:0]   pkt_in;
    logic               active;
    logic               push;
    logic               pop;
    logic               full;
    logic               push_ok;
    logic               drop;

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            slot <= '0;
            ts   <= '0;
        end else begin
            slot <= slot + 1'b1;
            if (slot == '1)
                ts <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            s1_i    <= '0;
            s1_q    <= '0;
            s1_slot <= '0;
            s1_ts   <= '0;
            s1_cap  <= 1'b0;
        end else begin
            s1_i    <= read_out_I;
            s1_q    <= read_out_Q;
            s1_slot <= slot;
            s1_ts   <= ts;
            s1_cap  <= cap_en;
        end
    end

    // Bus data lags the slot counter by SLOT_OFFSET cycles; modulo wrap is
    // implicit in the CH_BITS-wide subtraction.
    always_comb begin
        chan    = s1_slot - CH_BITS'(SLOT_OFFSET);
        pkt_in  = {s1_ts, chan, s1_i[0], s1_i[1], s1_q[0], s1_q[1]};
        active  = s1_i[0] | s1_q[0];
        push    = active & s1_cap;
        full    = (fifo_level == (FIFO_AW + 1)'(DEPTH));
        pop     = pkt.pkt_valid & pkt.pkt_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok = push & (~full | pop);
        drop    = push & full & ~pop;
    end

    always_ff @(posedge clk_master) begin
        if (push_ok)
            mem[wr_ptr] <= pkt_in;
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A drop on the clearing edge wins, so the counter restarts at one.
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr)
                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    always_comb begin
        pkt.pkt_valid = (fifo_level != '0);
        pkt.pkt_data  = pkt.pkt_valid ? mem[rd_ptr] : '0;
    end
endmodule

// File: tb/tb_ro_event_packer.sv
module tb_ro_event_packer;
    logic       clk_master = 1'b0;
    logic       rstb;
    logic       cap_en;
    logic [1:0] read_out_I;
    logic [1:0] read_out_Q;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;
    logic [7:0] drop_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;
    int unsigned edges;

    ro_event_packer_if #(.PKT_W(20)) pkt_bus ();

    ro_event_packer #(
        .CH_BITS    (4),
        .TS_BITS    (12),
        .SLOT_OFFSET(1),
        .FIFO_AW    (3)
    ) dut (
        .clk_master(clk_master),
        .rstb      (rstb),
        .cap_en    (cap_en),
        .read_out_I(read_out_I),
        .read_out_Q(read_out_Q),
        .pkt       (pkt_bus.master),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk_master = ~clk_master;

    // Index of the next bus sample edge since reset release.
    always @(posedge clk_master or negedge rstb) begin
        if (!rstb) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk_master);
    endtask

    task automatic goto(input int unsigned target);
        int unsigned guard = 0;
        while (edges < target && guard < 200000) begin
            @(negedge clk_master);
            guard++;
        end
    endtask

    // Packet expected for a sample taken at sample edge e.
    function automatic logic [19:0] pk(input int unsigned e, input logic [3:0] bits);
        logic [11:0] t;
        logic [3:0]  c;
        t = 12'((e / 16) % 4096);
        c = 4'(((e % 16) + 15) % 16);
        return {t, c, bits};
    endfunction

    initial begin
        int unsigned s0;
        rstb = 1'b0; cap_en = 1'b1; read_out_I = 2'b00; read_out_Q = 2'b00;
        ovf_clr = 1'b0; pkt_bus.pkt_ready = 1'b0;

        // Reset state
        cyc(2);
        check("rst_valid", 32'(pkt_bus.pkt_valid), 32'd0);
        check("rst_data", 32'(pkt_bus.pkt_data), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rstb = 1'b1;

        // 1: single I event in slot 5 of frame 0
        goto(5);
        read_out_I = 2'b01;
        cyc(1);
        read_out_I = 2'b00;
        check("t1_lat1_valid", 32'(pkt_bus.pkt_valid), 32'd0);
        cyc(1);
        check("t1_valid", 32'(pkt_bus.pkt_valid), 32'd1);
        check("t1_data", 32'(pkt_bus.pkt_data), 32'h00048);
        check("t1_level", 32'(fifo_level), 32'd1);
        pkt_bus.pkt_ready = 1'b1;
        cyc(1);
        pkt_bus.pkt_ready = 1'b0;
        check("t1_popped", 32'(pkt_bus.pkt_valid), 32'd0);

        // 2: I=11, Q=01 in slot 3 of frame 2
        goto(35);
        read_out_I = 2'b11; read_out_Q = 2'b01;
        cyc(1);
        read_out_I = 2'b00; read_out_Q = 2'b00;
        cyc(1);
        check("t2_data", 32'(pkt_bus.pkt_data), 32'h0022E);
        pkt_bus.pkt_ready = 1'b1;
        cyc(1);
        pkt_bus.pkt_ready = 1'b0;
        check("t2_level", 32'(fifo_level), 32'd0);

        // 3: 12 events with no consumer -> 8 stored, 4 dropped
        s0 = edges;
        read_out_I = 2'b01;
        cyc(12);
        read_out_I = 2'b00;
        cyc(1);
        check("t3_level", 32'(fifo_level), 32'd8);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_drop", 32'(drop_cnt), 32'd4);
        pkt_bus.pkt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_drain%0d", i), 32'(pkt_bus.pkt_data), 32'(pk(s0 + 32'(i), 4'b1000)));
            cyc(1);
        end
        check("t3_empty_valid", 32'(pkt_bus.pkt_valid), 32'd0);
        check("t3_empty_level", 32'(fifo_level), 32'd0);
        pkt_bus.pkt_ready = 1'b0;

        // 4: fill, then push+pop at full -> no drops
        s0 = edges;
        read_out_I = 2'b01;
        cyc(2);
        check("t4_head", 32'(pkt_bus.pkt_data), 32'(pk(s0, 4'b1000)));
        cyc(7);
        check("t4_head_stable", 32'(pkt_bus.pkt_data), 32'(pk(s0, 4'b1000)));
        check("t4_full", 32'(fifo_level), 32'd8);
        pkt_bus.pkt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check($sformatf("t4_level%0d", i), 32'(fifo_level), 32'd8);
            check($sformatf("t4_drop%0d", i), 32'(drop_cnt), 32'd4);
        end
        read_out_I = 2'b00;
        cyc(12);
        check("t4_drained", 32'(fifo_level), 32'd0);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("t4_clr_ovf", 32'(overflow), 32'd0);
        check("t4_clr_drop", 32'(drop_cnt), 32'd0);

        // 4b: drop on the same edge as ovf_clr -> drop wins
        pkt_bus.pkt_ready = 1'b0;
        read_out_I = 2'b01;
        cyc(9);
        read_out_I = 2'b00;
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("t4b_ovf", 32'(overflow), 32'd1);
        check("t4b_drop", 32'(drop_cnt), 32'd1);
        check("t4b_level", 32'(fifo_level), 32'd8);
        pkt_bus.pkt_ready = 1'b1;
        cyc(10);
        check("t4b_drained", 32'(fifo_level), 32'd0);

        // 5: polarity without event, capture disabled, in-flight packet
        pkt_bus.pkt_ready = 1'b0;
        read_out_I = 2'b10; read_out_Q = 2'b10;
        cyc(1);
        read_out_I = 2'b00; read_out_Q = 2'b00;
        cyc(2);
        check("t5_pol_only", 32'(fifo_level), 32'd0);
        cap_en = 1'b0;
        read_out_I = 2'b01;
        cyc(4);
        check("t5_cap_off", 32'(fifo_level), 32'd0);
        s0 = edges;
        cap_en = 1'b1;
        cyc(1);
        cap_en = 1'b0;
        cyc(1);
        check("t5_inflight_level", 32'(fifo_level), 32'd1);
        check("t5_inflight_data", 32'(pkt_bus.pkt_data), 32'(pk(s0, 4'b1000)));
        cyc(2);
        check("t5_no_more", 32'(fifo_level), 32'd1);
        read_out_I = 2'b00;
        cap_en = 1'b1;
        pkt_bus.pkt_ready = 1'b1;
        cyc(1);
        pkt_bus.pkt_ready = 1'b0;
        check("t5_drained", 32'(fifo_level), 32'd0);

        // 6: timestamp wrap at 2**16 sample edges
        goto(65535);
        read_out_I = 2'b01;
        cyc(1);
        read_out_I = 2'b00;
        cyc(1);
        check("t6_last_frame", 32'(pkt_bus.pkt_data), 32'hFFFE8);
        pkt_bus.pkt_ready = 1'b1;
        cyc(1);
        pkt_bus.pkt_ready = 1'b0;
        goto(65539);
        read_out_I = 2'b01;
        cyc(1);
        read_out_I = 2'b00;
        cyc(1);
        check("t6_wrapped", 32'(pkt_bus.pkt_data), 32'h00028);
        pkt_bus.pkt_ready = 1'b1;
        cyc(1);
        pkt_bus.pkt_ready = 1'b0;

        // 6b: asynchronous reset in the middle of traffic
        read_out_I = 2'b01;
        cyc(4);
        check("t6b_pre_level", 32'(fifo_level), 32'd3);
        #2 rstb = 1'b0;
        #1;
        check("t6b_valid", 32'(pkt_bus.pkt_valid), 32'd0);
        check("t6b_level", 32'(fifo_level), 32'd0);
        check("t6b_ovf", 32'(overflow), 32'd0);
        check("t6b_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk_master);
        rstb = 1'b1;
        cyc(1);
        read_out_I = 2'b00;
        cyc(1);
        check("t6b_first_level", 32'(fifo_level), 32'd1);
        check("t6b_first_data", 32'(pkt_bus.pkt_data), 32'h000F8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
